// File: rtl/uart_pkg.sv
// Shared UART types and constants: receiver states, oversample geometry.
// Used by uart_rx_os8 and the synchronizer-based TX/CTS path.
package uart_pkg;

    localparam int OS   = 8;
    localparam int MID  = 3;
    localparam int DW   = 8;
    localparam int BAUD = 9600;

    localparam logic [2:0] MID_TICK  = 3'(MID);
    localparam logic [2:0] LAST_TICK = 3'(OS - 1);
    localparam logic [2:0] LAST_BIT  = 3'(DW - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_HIGH
    } rx_state_t;

    // Even parity over data plus received parity bit; 1 means mismatch.
    function automatic logic even_par_err(input logic [DW:0] v);
        return ^v;
    endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for asynchronous single-bit inputs.
// RST_VAL selects the level both flops take in reset.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_os8.sv
// 8x-oversampled UART receiver, 8N1 with valid/ready byte output.
// Define UART_RX_PARITY_EN for 8E1 with a parity_err pulse output.
module uart_rx_os8
    import uart_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          os_tick,
    input  logic          rxd,
    output logic [DW-1:0] rx_data,
    output logic          rx_valid,
    input  logic          rx_ready,
    output logic          frame_err,
    output logic          overrun,
`ifdef UART_RX_PARITY_EN
    output logic          parity_err,
`endif
    output logic          busy
);

    rx_state_t     state;
    logic [2:0]    tick_cnt;
    logic [2:0]    bit_idx;
    logic [DW-1:0] shreg;
    logic          rxd_s;
    logic          accept;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rxd),
        .q   (rxd_s)
    );

    assign accept = rx_valid & rx_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            tick_cnt  <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
            if (accept)
                rx_valid <= 1'b0;

            if (os_tick) begin
                unique case (state)
                    IDLE: begin
                        if (!rxd_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    START: begin
                        // The edge tick is index 0, so verify on the tick
                        // whose index reaches MID.
                        if (tick_cnt + 3'd1 == MID_TICK) begin
                            if (!rxd_s) begin
                                state    <= DATA;
                                tick_cnt <= '0;
                                bit_idx  <= '0;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 3'd1;
                        end
                    end
                    DATA: begin
                        tick_cnt <= tick_cnt + 3'd1;
                        if (tick_cnt == LAST_TICK) begin
                            shreg <= {rxd_s, shreg[DW-1:1]};
                            if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end else begin
                                bit_idx <= bit_idx + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
`ifdef UART_RX_PARITY_EN
                        tick_cnt <= tick_cnt + 3'd1;
                        if (tick_cnt == LAST_TICK) begin
                            parity_err <= even_par_err({rxd_s, shreg});
                            state      <= STOP;
                        end
`else
                        state <= IDLE;
                        busy  <= 1'b0;
`endif
                    end
                    STOP: begin
                        tick_cnt <= tick_cnt + 3'd1;
                        if (tick_cnt == LAST_TICK) begin
                            if (rxd_s) begin
                                // An accept this cycle frees the holding slot.
                                if (rx_valid && !rx_ready) begin
                                    overrun <= 1'b1;
                                end else begin
                                    rx_data  <= shreg;
                                    rx_valid <= 1'b1;
                                end
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_HIGH;
                            end
                        end
                    end
                    WAIT_HIGH: begin
                        if (rxd_s) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_os8.sv
// Randomized scoreboard bench for uart_rx_os8.
// Frames are built bit-by-bit at tick granularity; a monitor pops bytes.
module tb_uart_rx_os8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       os_tick = 1'b0;
    logic       rxd = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic       busy;
`ifdef UART_RX_PARITY_EN
    logic       parity_err;
`endif

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int ticks = 0;
    int tick_cyc = 0;
    bit tick_stuck = 0;
    bit ready_rand = 0;

    logic [7:0] exp_q[$];
    int exp_ferr = 0;
    int seen_ferr = 0;
    int exp_perr = 0;
    int seen_perr = 0;

    bit   rose = 0;
    bit   rise_on_tick = 0;
    int   rise_ticks = 0;
    int   width = 0;
    int   last_width = 0;
    logic prev_valid = 1'b0;
    logic prev_xfer = 1'b0;
    logic [7:0] prev_data = '0;

    uart_rx_os8 dut (
        .clk       (clk),
        .rst       (rst),
        .os_tick   (os_tick),
        .rxd       (rxd),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
`ifdef UART_RX_PARITY_EN
        .parity_err(parity_err),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (os_tick) begin
            ticks    <= ticks + 1;
            tick_cyc <= cyc + 1;
        end
    end

    initial begin : tick_gen
        int div;
        div = 0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_stuck) begin
                os_tick = 1'b1;
            end else begin
                os_tick = (div == 3);
                div = (div + 1) % 4;
            end
        end
    end

    initial begin : ready_gen
        forever begin
            @(posedge clk);
            #1;
            if (ready_rand)
                rx_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin : watchdog
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, got %0d cycles, required < 200000", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
            prev_xfer  = 1'b0;
            width      = 0;
        end else begin
            if (frame_err)
                seen_ferr++;
`ifdef UART_RX_PARITY_EN
            if (parity_err)
                seen_perr++;
`endif
            if (rx_valid && !prev_valid) begin
                rose         = 1;
                rise_ticks   = ticks;
                rise_on_tick = (cyc == tick_cyc);
                width        = 0;
            end
            if (rx_valid)
                width++;
            if (!rx_valid && prev_valid)
                last_width = width;
            if (rx_valid && prev_valid && !prev_xfer)
                check("data_stable", rx_data, prev_data);
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0)
                    check("unexpected_byte", rx_data, 32'hxxxx_xxxx);
                else
                    check("rx_data", rx_data, exp_q.pop_front());
            end
            prev_valid = rx_valid;
            prev_xfer  = rx_valid && rx_ready;
            prev_data  = rx_data;
        end
    end

    task automatic wait_tick();
        @(posedge clk);
        while (!os_tick) @(posedge clk);
    endtask

    task automatic drive_bit(input logic b);
        #1;
        rxd = b;
        repeat (8) wait_tick();
    endtask

    task automatic idle_ticks(input int n);
        #1;
        rxd = 1'b1;
        repeat (n) wait_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop,
                              input logic par, input int gap,
                              output int k);
        wait_tick();
        #1;
        rxd = 1'b0;
        k = ticks;
        repeat (8) wait_tick();
        for (int i = 0; i < 8; i++)
            drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        drive_bit(par);
`else
        if (par === 1'bx)
            $display("parity bit unused");
`endif
        drive_bit(stop);
        if (gap > 0)
            idle_ticks(gap);
    endtask

    initial begin : main
        int k;
        int gap;
        logic [7:0] d;
        bit bad;

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_overrun", overrun, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rx_ready = 1'b1;
        idle_ticks(4);

        rose = 0;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 1'b0, 8, k);
        check("nominal_rose", rose, 1);
        check("nominal_rise_tick", rise_ticks, k + 76);
        check("nominal_rise_on_tick_edge", rise_on_tick, 1);
        check("nominal_valid_width", last_width, 1);
        check("nominal_frame_err", seen_ferr, 0);
        check("nominal_overrun", overrun, 0);

        rose = 0;
        wait_tick();
        #1;
        rxd = 1'b0;
        repeat (2) wait_tick();
        idle_ticks(12);
        @(negedge clk);
        check("false_start_busy", busy, 0);
        check("false_start_no_valid", rose, 0);
        check("false_start_no_ferr", seen_ferr, exp_ferr);
        exp_q.push_back(8'h3C);
        send_frame(8'h3C, 1'b1, 1'b0, 8, k);

        exp_ferr++;
        send_frame(8'h55, 1'b0, 1'b0, 0, k);
        #1;
        rxd = 1'b0;
        repeat (12) wait_tick();
        idle_ticks(10);
        check("framing_err_count", seen_ferr, exp_ferr);
        exp_q.push_back(8'h0F);
        send_frame(8'h0F, 1'b1, 1'b0, 8, k);

`ifdef UART_RX_PARITY_EN
        exp_q.push_back(8'h07);
        send_frame(8'h07, 1'b1, 1'b1, 8, k);
        check("parity_ok_no_err", seen_perr, exp_perr);
        exp_q.push_back(8'h07);
        exp_perr++;
        send_frame(8'h07, 1'b1, 1'b0, 8, k);
        check("parity_bad_err", seen_perr, exp_perr);
`endif

        ready_rand = 1;
        for (int i = 0; i < 18; i++) begin
            if (i == 12)
                tick_stuck = 1;
            d   = 8'($urandom);
            bad = ($urandom_range(0, 4) == 0);
            gap = $urandom_range(5, 20);
            if (bad) begin
                exp_ferr++;
                send_frame(d, 1'b0, ^d, 0, k);
                #1;
                rxd = 1'b0;
                repeat ($urandom_range(0, 12)) wait_tick();
                idle_ticks(gap);
            end else begin
                exp_q.push_back(d);
                send_frame(d, 1'b1, ^d, gap, k);
            end
        end
        tick_stuck = 0;
        idle_ticks(8);
        check("random_frame_err_count", seen_ferr, exp_ferr);

        ready_rand = 0;
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        for (int i = 0; i < 100 && rx_valid; i++) @(posedge clk);
        #1;
        rx_ready = 1'b0;
        exp_q.push_back(8'h11);
        send_frame(8'h11, 1'b1, 1'b0, 6, k);
        send_frame(8'h22, 1'b1, 1'b0, 6, k);
        @(negedge clk);
        check("overrun_set", overrun, 1);
        check("overrun_valid_held", rx_valid, 1);
        check("overrun_old_data", rx_data, 8'h11);
        @(posedge clk);
        #1;
        rx_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("overrun_valid_cleared", rx_valid, 0);
        check("overrun_sticky", overrun, 1);

        wait_tick();
        #1;
        rxd = 1'b0;
        repeat (8) wait_tick();
        for (int i = 0; i < 4; i++)
            drive_bit(1'b1);
        repeat (4) wait_tick();
        #1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("midrst_rx_valid", rx_valid, 0);
        check("midrst_rx_data", rx_data, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_overrun", overrun, 0);
        check("midrst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_ticks(40);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 1'b0, 8, k);

        for (int i = 0; i < 5000 && exp_q.size() != 0; i++)
            @(posedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        check("final_frame_err_count", seen_ferr, exp_ferr);
        check("final_parity_err_count", seen_perr, exp_perr);
        check("final_overrun_clear", overrun, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
